// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared widths, packet field bounds and FSM states for the spike scheduler
package sched_pkg;

  localparam int AXON_W  = 256;
  localparam int SLOT_AW = 4;
  localparam int PKT_W   = 12;

  localparam int AXON_MSB  = 11;
  localparam int AXON_LSB  = 4;
  localparam int DELAY_MSB = 3;
  localparam int DELAY_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DELIVER = 2'd1,
    S_CLEAR   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with a one-bit priority pointer
module rr_arbiter2
  import sched_pkg::*;
#(
  parameter int W = PKT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] pkt_a,
  input  logic [W-1:0] pkt_b,
  output logic         grant_a,
  output logic         grant_b,
  output logic         accept,
  output logic [W-1:0] pkt
);

  // ptr == 0 favours source a on a tie, ptr == 1 favours source b
  logic ptr;

  always_comb begin
    grant_a = en & req_a & (~req_b | ~ptr);
    grant_b = en & req_b & (~req_a | ptr);
    accept  = grant_a | grant_b;
    pkt     = '0;
    if (grant_a)
      pkt = pkt_a;
    else if (grant_b)
      pkt = pkt_b;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ptr <= 1'b0;
    else if (grant_a)
      ptr <= 1'b1;
    else if (grant_b)
      ptr <= 1'b0;
  end

endmodule

// File: rtl/scheduler_ctrl.sv
// rtl/scheduler_ctrl.sv - arbitrates packet writes and sequences per-tick slot delivery and clear
module scheduler_ctrl #(
  parameter int AXON_W  = sched_pkg::AXON_W,
  parameter int SLOT_AW = sched_pkg::SLOT_AW,
  parameter int PKT_W   = sched_pkg::PKT_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick,
  input  logic               rt_valid,
  input  logic [PKT_W-1:0]   rt_packet,
  output logic               rt_ready,
  input  logic               lb_valid,
  input  logic [PKT_W-1:0]   lb_packet,
  output logic               lb_ready,
  output logic               sram_wen,
  output logic               sram_clr,
  output logic [SLOT_AW-1:0] sram_read_address,
  output logic [PKT_W-1:0]   sram_packet,
  input  logic [AXON_W-1:0]  sram_out,
  output logic               axon_valid,
  output logic [AXON_W-1:0]  axon_vector,
  input  logic               axon_ready,
  output logic               tick_done,
  output logic               tick_overrun
);

  import sched_pkg::*;

  state_t state;
  logic   tick_pending;
  logic   arb_en;

  // Writes are only taken in IDLE so a delay-15 write to the read slot never races delivery or clear
  assign arb_en      = reset_n & (state == S_IDLE);
  assign axon_valid  = (state == S_DELIVER);
  assign sram_clr    = (state == S_CLEAR);
  assign axon_vector = sram_out;

  rr_arbiter2 #(.W(PKT_W)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (arb_en),
    .req_a   (rt_valid),
    .req_b   (lb_valid),
    .pkt_a   (rt_packet),
    .pkt_b   (lb_packet),
    .grant_a (rt_ready),
    .grant_b (lb_ready),
    .accept  (sram_wen),
    .pkt     (sram_packet)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      sram_read_address <= '0;
      tick_pending      <= 1'b0;
      tick_overrun      <= 1'b0;
      tick_done         <= 1'b0;
    end else begin
      tick_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick || tick_pending) begin
            state        <= S_DELIVER;
            tick_pending <= 1'b0;
          end
        end
        S_DELIVER: begin
          if (tick) begin
            if (tick_pending)
              tick_overrun <= 1'b1;
            tick_pending <= 1'b1;
          end
          if (axon_ready)
            state <= S_CLEAR;
        end
        S_CLEAR: begin
          sram_read_address <= sram_read_address + SLOT_AW'(1);
          tick_done         <= 1'b1;
          if (tick && tick_pending)
            tick_overrun <= 1'b1;
          // A queued (or freshly arrived) tick skips IDLE and consumes the single queue entry
          if (tick || tick_pending) begin
            state        <= S_DELIVER;
            tick_pending <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scheduler_ctrl.sv
// tb/tb_scheduler_ctrl.sv - directed self-checking bench for scheduler_ctrl with a behavioural slot SRAM
module tb_scheduler_ctrl;
  import sched_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               tick = 1'b0;
  logic               rt_valid = 1'b0;
  logic [PKT_W-1:0]   rt_packet = '0;
  logic               lb_valid = 1'b0;
  logic [PKT_W-1:0]   lb_packet = '0;
  logic               axon_ready = 1'b1;
  logic               rt_ready, lb_ready, sram_wen, sram_clr;
  logic [SLOT_AW-1:0] sram_read_address;
  logic [PKT_W-1:0]   sram_packet;
  logic [AXON_W-1:0]  sram_out, axon_vector;
  logic               axon_valid, tick_done, tick_overrun;

  int errors = 0;
  int checks = 0;
  int done_count = 0;
  int clr_count = 0;
  int wen_count = 0;

  always #5 clk = ~clk;

  scheduler_ctrl dut (
    .clk (clk), .reset_n (reset_n), .tick (tick),
    .rt_valid (rt_valid), .rt_packet (rt_packet), .rt_ready (rt_ready),
    .lb_valid (lb_valid), .lb_packet (lb_packet), .lb_ready (lb_ready),
    .sram_wen (sram_wen), .sram_clr (sram_clr), .sram_read_address (sram_read_address),
    .sram_packet (sram_packet), .sram_out (sram_out),
    .axon_valid (axon_valid), .axon_vector (axon_vector), .axon_ready (axon_ready),
    .tick_done (tick_done), .tick_overrun (tick_overrun)
  );

  // Slot SRAM: a packet with delay d lands in slot read_address + d + 1 (mod 16)
  logic [AXON_W-1:0]  mem [16];
  logic [SLOT_AW-1:0] wslot;
  logic [SLOT_AW-1:0] last_wslot = '0;
  assign wslot    = sram_read_address + sram_packet[DELAY_MSB:DELAY_LSB] + 4'd1;
  assign sram_out = mem[sram_read_address];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (sram_clr) mem[sram_read_address] <= '0;
      if (sram_wen) begin
        mem[wslot][sram_packet[AXON_MSB:AXON_LSB]] <= 1'b1;
        last_wslot <= wslot;
      end
    end
  end

  always @(posedge clk) begin
    if (tick_done) done_count <= done_count + 1;
    if (sram_clr)  clr_count  <= clr_count + 1;
    if (sram_wen)  wen_count  <= wen_count + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; tick = 1'b0; rt_valid = 1'b0; lb_valid = 1'b0; axon_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_tick(output logic [AXON_W-1:0] vec, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    vec = axon_vector;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (tick_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rt_valid = 1'b1;
    rt_packet = 12'h053;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rt_ready !== 1'b0) begin errors++; $display("FAIL reset_rt_ready: got %b want 0", rt_ready); end
    checks++; if (sram_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", sram_wen); end
    checks++; if (axon_valid !== 1'b0) begin errors++; $display("FAIL reset_axon_valid: got %b want 0", axon_valid); end
    checks++; if (sram_clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", sram_clr); end
    checks++; if (sram_read_address !== 4'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", sram_read_address); end
    checks++; if (sram_packet !== 12'h000) begin errors++; $display("FAIL reset_packet: got %h want 000", sram_packet); end
    checks++; if ({tick_done, tick_overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {tick_done, tick_overrun}); end
    rt_valid = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [AXON_W-1:0] vec;
    logic [AXON_W-1:0] exp_vec;
    bit ok;
    @(negedge clk);
    rt_valid = 1'b1; rt_packet = 12'h053;
    #1;
    checks++; if ({rt_ready, sram_wen} !== 2'b11) begin errors++; $display("FAIL pkt_accept: got %b want 11", {rt_ready, sram_wen}); end
    checks++; if (sram_packet !== 12'h053) begin errors++; $display("FAIL pkt_sram_packet: got %h want 053", sram_packet); end
    @(negedge clk);
    rt_valid = 1'b0;
    checks++; if (last_wslot !== 4'd4) begin errors++; $display("FAIL pkt_slot: got %0d want 4", last_wslot); end
    for (int t = 0; t < 5; t++) begin
      do_tick(vec, ok);
      exp_vec = '0;
      if (t == 4) exp_vec[5] = 1'b1;
      checks++; if (!ok) begin errors++; $display("FAIL pkt_tick_done_%0d: timeout want tick_done", t); end
      checks++; if (vec !== exp_vec) begin errors++; $display("FAIL pkt_vector_%0d: got %h want %h", t, vec, exp_vec); end
    end
    checks++; if (mem[4] !== '0) begin errors++; $display("FAIL pkt_slot4_cleared: got %h want 0", mem[4]); end
    checks++; if (sram_read_address !== 4'd5) begin errors++; $display("FAIL pkt_addr: got %0d want 5", sram_read_address); end
  endtask

  task automatic test_arbiter();
    logic [PKT_W-1:0] rpk [2];
    logic [PKT_W-1:0] lpk [2];
    logic [PKT_W-1:0] exp_pkt [4];
    logic [AXON_W-1:0] exp_vec;
    int rc = 0;
    int lc = 0;
    int wen0;
    rpk = '{12'h010, 12'h020};
    lpk = '{12'h030, 12'h040};
    exp_pkt = '{12'h010, 12'h030, 12'h020, 12'h040};
    do_reset();
    wen0 = wen_count;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rt_valid = 1'b1; lb_valid = 1'b1;
      rt_packet = rpk[rc]; lb_packet = lpk[lc];
      #1;
      checks++; if ({rt_ready, lb_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL arb_grant_%0d: got %b want %b", i, {rt_ready, lb_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if ({sram_wen, sram_packet} !== {1'b1, exp_pkt[i]}) begin errors++; $display("FAIL arb_write_%0d: got %b/%h want 1/%h", i, sram_wen, sram_packet, exp_pkt[i]); end
      if (i % 2 == 0) rc++; else lc++;
      if (rc > 1) rc = 1;
      if (lc > 1) lc = 1;
    end
    @(negedge clk);
    rt_valid = 1'b0; lb_valid = 1'b0;
    exp_vec = '0;
    exp_vec[4:1] = 4'hF;
    checks++; if (mem[1] !== exp_vec) begin errors++; $display("FAIL arb_no_loss: got %h want %h", mem[1], exp_vec); end
    checks++; if (wen_count - wen0 !== 4) begin errors++; $display("FAIL arb_wen_count: got %0d want 4", wen_count - wen0); end
  endtask

  task automatic test_stall();
    int clr0 = clr_count;
    @(negedge clk);
    axon_ready = 1'b0; tick = 1'b1;
    rt_valid = 1'b1; rt_packet = 12'h011;
    @(negedge clk);
    tick = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({axon_valid, rt_ready, lb_ready, sram_wen} !== 4'b1000) begin errors++; $display("FAIL stall_cycle_%0d: got %b want 1000", k, {axon_valid, rt_ready, lb_ready, sram_wen}); end
      @(negedge clk);
    end
    axon_ready = 1'b1;
    @(negedge clk);
    checks++; if ({sram_clr, rt_ready} !== 2'b10) begin errors++; $display("FAIL stall_clear: got %b want 10", {sram_clr, rt_ready}); end
    @(negedge clk);
    checks++; if ({tick_done, rt_ready, axon_valid} !== 3'b110) begin errors++; $display("FAIL stall_done_accept: got %b want 110", {tick_done, rt_ready, axon_valid}); end
    @(negedge clk);
    rt_valid = 1'b0;
    checks++; if (clr_count - clr0 !== 1) begin errors++; $display("FAIL stall_clr_count: got %0d want 1", clr_count - clr0); end
  endtask

  task automatic test_delay15();
    logic [AXON_W-1:0] vec;
    bit ok;
    for (int t = 0; t < 5; t++) do_tick(vec, ok);
    checks++; if (sram_read_address !== 4'd6) begin errors++; $display("FAIL d15_pre_addr: got %0d want 6", sram_read_address); end
    @(negedge clk);
    axon_ready = 1'b0; tick = 1'b1;
    rt_valid = 1'b1; rt_packet = 12'h0AF;
    @(negedge clk);
    tick = 1'b0;
    checks++; if ({rt_ready, sram_wen} !== 2'b00) begin errors++; $display("FAIL d15_blocked_deliver: got %b want 00", {rt_ready, sram_wen}); end
    axon_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rt_ready, sram_wen} !== 2'b00) begin errors++; $display("FAIL d15_blocked_clear: got %b want 00", {rt_ready, sram_wen}); end
    @(negedge clk);
    checks++; if ({sram_read_address, rt_ready, sram_wen} !== {4'd7, 2'b11}) begin errors++; $display("FAIL d15_accept: got %0d/%b want 7/11", sram_read_address, {rt_ready, sram_wen}); end
    @(negedge clk);
    rt_valid = 1'b0;
    checks++; if (last_wslot !== 4'd7) begin errors++; $display("FAIL d15_slot: got %0d want 7", last_wslot); end
    checks++; if (mem[7][10] !== 1'b1) begin errors++; $display("FAIL d15_bit: got %b want 1", mem[7][10]); end
  endtask

  task automatic test_overrun();
    checks++; if (tick_overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial: got %b want 0", tick_overrun); end
    @(negedge clk);
    axon_ready = 1'b0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
    end
    checks++; if ({axon_valid, tick_overrun} !== 2'b11) begin errors++; $display("FAIL ovr_flag: got %b want 11", {axon_valid, tick_overrun}); end
    axon_ready = 1'b1;
    @(negedge clk);
    checks++; if (sram_clr !== 1'b1) begin errors++; $display("FAIL ovr_clear1: got %b want 1", sram_clr); end
    @(negedge clk);
    checks++; if ({axon_valid, tick_done} !== 2'b11) begin errors++; $display("FAIL ovr_back_to_back: got %b want 11", {axon_valid, tick_done}); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({axon_valid, tick_done, tick_overrun} !== 3'b011) begin errors++; $display("FAIL ovr_sticky: got %b want 011", {axon_valid, tick_done, tick_overrun}); end
    @(negedge clk);
    checks++; if ({axon_valid, tick_overrun} !== 2'b01) begin errors++; $display("FAIL ovr_no_third: got %b want 01", {axon_valid, tick_overrun}); end
    do_reset();
    #1;
    checks++; if (tick_overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset_clear: got %b want 0", tick_overrun); end
  endtask

  task automatic test_wrap();
    logic [AXON_W-1:0] vec;
    bit ok;
    int done0;
    do_reset();
    done0 = done_count;
    for (int i = 0; i < 17; i++) begin
      do_tick(vec, ok);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_tick_done_%0d: timeout want tick_done", i); end
      if (i == 14) begin
        checks++; if (sram_read_address !== 4'd15) begin errors++; $display("FAIL wrap_addr15: got %0d want 15", sram_read_address); end
      end
      if (i == 15) begin
        checks++; if (sram_read_address !== 4'd0) begin errors++; $display("FAIL wrap_addr0: got %0d want 0", sram_read_address); end
      end
    end
    @(negedge clk);
    checks++; if (sram_read_address !== 4'd1) begin errors++; $display("FAIL wrap_final_addr: got %0d want 1", sram_read_address); end
    checks++; if (done_count - done0 !== 17) begin errors++; $display("FAIL wrap_done_count: got %0d want 17", done_count - done0); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_arbiter();
    test_stall();
    test_delay15();
    test_overrun();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
